// File: rtl/mips_defs.sv
// Shared definitions for the MEM stage: byte-enable patterns and the data
// memory geometry.
package mips_defs;

    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_HLO  = 4'b0011;
    localparam logic [3:0] BE_HHI  = 4'b1100;
    localparam logic [3:0] BE_B0   = 4'b0001;
    localparam logic [3:0] BE_B1   = 4'b0010;
    localparam logic [3:0] BE_B2   = 4'b0100;
    localparam logic [3:0] BE_B3   = 4'b1000;

    localparam int          DM_DEPTH = 3072;
    localparam logic [31:0] DM_BASE  = 32'h0000_0000;
    localparam int          DM_IDXW  = 12;

    typedef enum logic [1:0] {
        LANE_WORD,
        LANE_HALF,
        LANE_BYTE,
        LANE_NONE
    } lane_mode_e;

    // Classify a BE mask into the lane-steering mode it implies.
    // Anything outside the seven legal patterns is LANE_NONE.
    function automatic lane_mode_e be_decode(input logic [3:0] be);
        lane_mode_e mode;
        case (be)
            BE_WORD:                      mode = LANE_WORD;
            BE_HLO, BE_HHI:               mode = LANE_HALF;
            BE_B0, BE_B1, BE_B2, BE_B3:   mode = LANE_BYTE;
            default:                      mode = LANE_NONE;
        endcase
        return mode;
    endfunction

endpackage

// File: rtl/dm_lane_merge.sv
// Combinational lane steering and byte-masked merge of store data into the
// currently stored word.
module dm_lane_merge
    import mips_defs::*;
(
    input  logic [3:0]  be,
    input  logic [31:0] wd,
    input  logic [31:0] old_word,
    output logic [31:0] new_word,
    output logic        be_legal
);

    lane_mode_e  mode;
    logic [31:0] lanes;

    // Replicate the raw rt value onto every lane it could target, then let
    // the BE mask pick which lanes actually replace the old bytes.
    always_comb begin
        mode     = be_decode(be);
        lanes    = wd;
        be_legal = 1'b1;
        case (mode)
            LANE_WORD: lanes = wd;
            LANE_HALF: lanes = {wd[15:0], wd[15:0]};
            LANE_BYTE: lanes = {4{wd[7:0]}};
            default: begin
                lanes    = wd;
                be_legal = 1'b0;
            end
        endcase
        new_word = old_word;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) begin
                new_word[8*k +: 8] = lanes[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/dm_be_ram.sv
// Byte-enabled data memory for the MEM stage: asynchronous word read,
// masked word write, registered write-log record and saturating store count.
module dm_be_ram
    import mips_defs::*;
#(
    parameter int          DEPTH = DM_DEPTH,
    parameter logic [31:0] BASE  = DM_BASE,
    parameter int          IDXW  = DM_IDXW
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    input  logic [3:0]  BE,
    input  logic        WE,
    input  logic [31:0] PC,
    output logic [31:0] RD,
    output logic        in_range,
    output logic        be_err,
    output logic        wlog_valid,
    output logic [31:0] wlog_pc,
    output logic [31:0] wlog_addr,
    output logic [31:0] wlog_data,
    output logic [15:0] store_cnt
);

    localparam logic [31:0] SPAN = 32'(DEPTH * 4);

    logic [31:0]     mem [DEPTH];
    logic [31:0]     offset;
    logic [IDXW-1:0] idx;
    logic [31:0]     old_word;
    logic [31:0]     new_word;
    logic            be_legal;
    logic            commit;

    // Address decode; the offset compare is unsigned so addresses below BASE
    // wrap to large values and fall out of range.
    always_comb begin
        offset   = A - BASE;
        in_range = (offset < SPAN);
        idx      = offset[IDXW+1:2];
        old_word = in_range ? mem[idx] : 32'h0;
        RD       = old_word;
        commit   = WE && in_range && be_legal && !reset;
    end

    dm_lane_merge u_merge (
        .be       (BE),
        .wd       (WD),
        .old_word (old_word),
        .new_word (new_word),
        .be_legal (be_legal)
    );

    // Array update: reset clears every word, otherwise a committed store
    // replaces the word with the merged value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'h0;
            end
        end else if (commit) begin
            mem[idx] <= new_word;
        end
    end

    // Write-log record and illegal-BE flag; log fields hold between commits.
    always_ff @(posedge clk) begin
        if (reset) begin
            wlog_valid <= 1'b0;
            be_err     <= 1'b0;
            wlog_pc    <= 32'h0;
            wlog_addr  <= 32'h0;
            wlog_data  <= 32'h0;
        end else begin
            wlog_valid <= commit;
            be_err     <= WE && in_range && !be_legal;
            if (commit) begin
                wlog_pc   <= PC;
                wlog_addr <= {A[31:2], 2'b00};
                wlog_data <= new_word;
            end
        end
    end

    // Committed-store counter, pinned at all-ones once it gets there.
    always_ff @(posedge clk) begin
        if (reset) begin
            store_cnt <= 16'h0;
        end else if (commit && (store_cnt != 16'hFFFF)) begin
            store_cnt <= store_cnt + 16'h1;
        end
    end

endmodule
